// File: rtl/dmem_arbiter_pkg.sv
// Shared core package for the data-memory path.
// Holds the RV32I load/store funct3 codes, the arbiter state enum, the
// memory-request bundle and the access-fault check used by dmem_fault_chk.
package dmem_arbiter_pkg;

  // RV32I load funct3
  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  // RV32I store funct3
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DBG = 2'd2
  } arb_state_e;

  // Address/data/size presented to the memory for one access
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fn3;
  } mem_req_t;

  // Range is checked in 33 bits so a window ending at 2^32 cannot wrap.
  function automatic logic dmem_fault(input logic [31:0] addr,
                                      input logic [2:0]  fn3,
                                      input logic        we,
                                      input logic [31:0] base,
                                      input logic [32:0] bytes);
    logic [32:0] a, lo, hi;
    logic        oor, bad_fn3, misal;
    a   = {1'b0, addr};
    lo  = {1'b0, base};
    hi  = lo + bytes;
    oor = (a < lo) || (a >= hi);
    if (we) bad_fn3 = !(fn3 inside {FN3_SB, FN3_SH, FN3_SW});
    else    bad_fn3 = !(fn3 inside {FN3_LB, FN3_LH, FN3_LW, FN3_LBU, FN3_LHU});
    // fn3[1:0] encodes access size for every legal code
    misal = ((fn3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
            ((fn3[1:0] == 2'b01) && addr[0]);
    return oor | bad_fn3 | misal;
  endfunction

endpackage

// File: rtl/dmem_fault_chk.sv
// Combinational access-fault check for one requester port.
// Ports: addr/fn3/we of the request in, fault out (range, alignment or
// undefined funct3).
module dmem_fault_chk
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
  parameter int          MEM_BYTES = 16384
) (
  input  logic [31:0] addr,
  input  logic [2:0]  fn3,
  input  logic        we,
  output logic        fault
);
  assign fault = dmem_fault(addr, fn3, we, BASE_ADDR, 33'(MEM_BYTES));
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU, debug/loader) arbiter in front of a single data memory.
// Ports: cpu_* and dbg_* request groups (req/we/addr/wdata/fn3 in,
// gnt/rvalid/err/rdata out); mem_addr/mem_wdata/mem_we/mem_fn3 to memory,
// mem_rdata from memory one clock after the address.
// Grants are combinational in IDLE; a load parks in RD_CPU/RD_DBG for the
// single return cycle. CPU has priority until debug has waited STARVE_MAX
// consecutive CPU grants.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_2000,
  parameter int          MEM_BYTES  = 16384,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_fn3,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_fn3,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_fn3,
  input  logic [31:0] mem_rdata
);
  localparam int NP    = 2;  // port 0 = CPU, port 1 = debug
  localparam int P_CPU = 0;
  localparam int P_DBG = 1;
  localparam int CW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [NP-1:0]        req, we, fault, gnt, rvalid, err;
  logic [NP-1:0][31:0]  addr, wdata, rdata;
  logic [NP-1:0][2:0]   fn3;

  assign req   = {dbg_req,   cpu_req};
  assign we    = {dbg_we,    cpu_we};
  assign addr  = {dbg_addr,  cpu_addr};
  assign wdata = {dbg_wdata, cpu_wdata};
  assign fn3   = {dbg_fn3,   cpu_fn3};

  for (genvar p = 0; p < NP; p++) begin : g_chk
    dmem_fault_chk #(.BASE_ADDR(BASE_ADDR), .MEM_BYTES(MEM_BYTES)) u_chk (
      .addr  (addr[p]),
      .fn3   (fn3[p]),
      .we    (we[p]),
      .fault (fault[p])
    );
  end

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          pend_fault_q, pend_fault_d;
  mem_req_t      hold_q, mem_req;
  logic          dbg_win, sel;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    pend_fault_d = pend_fault_q;
    gnt          = '0;
    rvalid       = '0;
    err          = '0;
    rdata        = '0;
    mem_req      = hold_q;
    mem_we       = 1'b0;
    dbg_win      = 1'b0;
    sel          = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps the combinational grant quiet while in reset
        if (rst_n) begin
          dbg_win    = req[P_DBG] && (!req[P_CPU] || (starve_q == SMAX));
          gnt[P_DBG] = dbg_win;
          gnt[P_CPU] = req[P_CPU] && !dbg_win;
        end
        if (|gnt) begin
          sel     = gnt[P_DBG];
          mem_req = '{addr: addr[sel], wdata: wdata[sel], fn3: fn3[sel]};
          mem_we  = we[sel] & ~fault[sel];
          if (we[sel]) begin
            err[sel] = fault[sel];
          end else begin
            state_d      = sel ? RD_DBG : RD_CPU;
            pend_fault_d = fault[sel];
          end
        end
        if (gnt[P_DBG])
          starve_d = '0;
        else if (gnt[P_CPU] && req[P_DBG] && (starve_q != SMAX))
          starve_d = starve_q + CW'(1);
      end
      RD_CPU: begin
        rvalid[P_CPU] = 1'b1;
        err[P_CPU]    = pend_fault_q;
        rdata[P_CPU]  = pend_fault_q ? 32'h0 : mem_rdata;
        state_d       = IDLE;
      end
      RD_DBG: begin
        rvalid[P_DBG] = 1'b1;
        err[P_DBG]    = pend_fault_q;
        rdata[P_DBG]  = pend_fault_q ? 32'h0 : mem_rdata;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!req[P_DBG]) starve_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      pend_fault_q <= 1'b0;
      hold_q       <= '{addr: BASE_ADDR, wdata: 32'h0, fn3: FN3_LW};
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      pend_fault_q <= pend_fault_d;
      if (|gnt) hold_q <= mem_req;
    end
  end

  assign mem_addr   = mem_req.addr;
  assign mem_wdata  = mem_req.wdata;
  assign mem_fn3    = mem_req.fn3;

  assign cpu_gnt    = gnt[P_CPU];
  assign cpu_rvalid = rvalid[P_CPU];
  assign cpu_err    = err[P_CPU];
  assign cpu_rdata  = rdata[P_CPU];
  assign dbg_gnt    = gnt[P_DBG];
  assign dbg_rvalid = rvalid[P_DBG];
  assign dbg_err    = err[P_DBG];
  assign dbg_rdata  = rdata[P_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter plus hand sequences for
// debug starvation and reset during a pending load.
module tb_dmem_arbiter;
  localparam logic [31:0] B = 32'h8000_2000;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [2:0]  cpu_fn3, dbg_fn3;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_fn3;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_fn3(cpu_fn3), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_fn3(dbg_fn3), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err),
    .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_fn3(mem_fn3),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at mem_addr[5:2], returned one clock later
  logic [31:0] tbmem [16];
  always @(posedge clk) mem_rdata <= tbmem[mem_addr[5:2]];

  typedef struct packed {
    logic creq, cwe; logic [31:0] caddr, cwd; logic [2:0] cfn3;
    logic dreq, dwe; logic [31:0] daddr, dwd; logic [2:0] dfn3;
  } in_t;
  typedef struct packed {
    logic cg, dg, cv, dv, ce, de; logic [31:0] crd, drd; logic mwe; logic [31:0] maddr;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic in_t CI(input logic w, input logic [31:0] a, d, input logic [2:0] f);
    return '{creq:1'b1, cwe:w, caddr:a, cwd:d, cfn3:f, dreq:1'b0, dwe:1'b0, daddr:32'h0, dwd:32'h0, dfn3:3'h0};
  endfunction
  function automatic in_t DI(input logic w, input logic [31:0] a, d, input logic [2:0] f);
    return '{creq:1'b0, cwe:1'b0, caddr:32'h0, cwd:32'h0, cfn3:3'h0, dreq:1'b1, dwe:w, daddr:a, dwd:d, dfn3:f};
  endfunction
  function automatic in_t NI();
    return '0;
  endfunction
  function automatic out_t O(input logic cg, dg, cv, dv, ce, de, input logic [31:0] crd, drd,
                             input logic mwe, input logic [31:0] maddr);
    return '{cg:cg, dg:dg, cv:cv, dv:dv, ce:ce, de:de, crd:crd, drd:drd, mwe:mwe, maddr:maddr};
  endfunction

  task automatic drive(input in_t x);
    cpu_req = x.creq; cpu_we = x.cwe; cpu_addr = x.caddr; cpu_wdata = x.cwd; cpu_fn3 = x.cfn3;
    dbg_req = x.dreq; dbg_we = x.dwe; dbg_addr = x.daddr; dbg_wdata = x.dwd; dbg_fn3 = x.dfn3;
  endtask

  task automatic chk(input string name, input out_t e);
    out_t a;
    a = '{cg:cpu_gnt, dg:dbg_gnt, cv:cpu_rvalid, dv:dbg_rvalid, ce:cpu_err, de:dbg_err,
          crd:cpu_rdata, drd:dbg_rdata, mwe:mem_we, maddr:mem_addr};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b%b rv=%b%b err=%b%b crd=%h drd=%h we=%b addr=%h, want gnt=%b%b rv=%b%b err=%b%b crd=%h drd=%h we=%b addr=%h",
               name, a.cg, a.dg, a.cv, a.dv, a.ce, a.de, a.crd, a.drd, a.mwe, a.maddr,
               e.cg, e.dg, e.cv, e.dv, e.ce, e.de, e.crd, e.drd, e.mwe, e.maddr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbmem[i] = 32'h1111_0000 + i;
    tbmem[1] = 32'hDEAD_BEEF;

    //            cg  dg  cv  dv  ce  de  crd           drd    mwe  maddr
    tv[0]  = '{NI(),                                    O(0,0,0,0,0,0,32'h0,0,0,B)};
    tv[1]  = '{CI(0, B+4, 32'h0, 3'b010),               O(1,0,0,0,0,0,32'h0,0,0,B+4)};          // LW
    tv[2]  = '{NI(),                                    O(0,0,1,0,0,0,32'hDEAD_BEEF,0,0,B+4)};
    tv[3]  = '{CI(1, B+8, 32'h1234_5678, 3'b010),       O(1,0,0,0,0,0,32'h0,0,1,B+8)};          // SW
    tv[4]  = '{CI(1, B+1, 32'h0, 3'b001),               O(1,0,0,0,1,0,32'h0,0,0,B+1)};          // SH misaligned
    tv[5]  = '{DI(0, 32'h8000_6000, 32'h0, 3'b010),     O(0,1,0,0,0,0,32'h0,0,0,32'h8000_6000)}; // out of range
    tv[6]  = '{NI(),                                    O(0,0,0,1,0,1,32'h0,0,0,32'h8000_6000)};
    tv[7]  = '{CI(0, B+3, 32'h0, 3'b000),               O(1,0,0,0,0,0,32'h0,0,0,B+3)};          // LB vs SB
    tv[7].i.dreq = 1'b1; tv[7].i.dwe = 1'b1; tv[7].i.daddr = B+5; tv[7].i.dwd = 32'hAA; tv[7].i.dfn3 = 3'b000;
    tv[8]  = '{DI(1, B+5, 32'hAA, 3'b000),              O(0,0,1,0,0,0,32'h1111_0000,0,0,B+3)};
    tv[9]  = '{DI(1, B+5, 32'hAA, 3'b000),              O(0,1,0,0,0,0,32'h0,0,1,B+5)};
    tv[10] = '{CI(0, B, 32'h0, 3'b011),                 O(1,0,0,0,0,0,32'h0,0,0,B)};            // bad fn3
    tv[11] = '{NI(),                                    O(0,0,1,0,1,0,32'h0,0,0,B)};
    tv[12] = '{CI(0, B+2, 32'h0, 3'b001),               O(1,0,0,0,0,0,32'h0,0,0,B+2)};          // LH back-to-back
    tv[13] = '{CI(0, B+2, 32'h0, 3'b001),               O(0,0,1,0,0,0,32'h1111_0000,0,0,B+2)};
    tv[14] = '{CI(0, B+2, 32'h0, 3'b001),               O(1,0,0,0,0,0,32'h0,0,0,B+2)};
    tv[15] = '{NI(),                                    O(0,0,1,0,0,0,32'h1111_0000,0,0,B+2)};
    tv[16] = '{CI(0, B+32'h3FFC, 32'h0, 3'b010),        O(1,0,0,0,0,0,32'h0,0,0,B+32'h3FFC)};   // last word
    tv[17] = '{NI(),                                    O(0,0,1,0,0,0,32'h1111_000F,0,0,B+32'h3FFC)};
    tv[18] = '{CI(0, B-4, 32'h0, 3'b010),               O(1,0,0,0,0,0,32'h0,0,0,B-4)};          // below window
    tv[19] = '{NI(),                                    O(0,0,1,0,1,0,32'h0,0,0,B-4)};
    tv[20] = '{CI(1, B+2, 32'h5, 3'b010),               O(1,0,0,0,1,0,32'h0,0,0,B+2)};          // SW misaligned

    // Reset with a request pending: no grant, reset values on mem_*
    rst_n = 1'b1;
    drive(CI(0, B+4, 32'h0, 3'b010));
    #1 rst_n = 1'b0;
    #1 chk("reset", O(0,0,0,0,0,0,32'h0,0,0,B));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].i);
      #1 chk($sformatf("vec%0d", k), tv[k].o);
      @(negedge clk);
    end

    // Starvation: both ports hold store requests; debug gets every 5th slot
    drive(CI(1, B+8, 32'h1, 3'b010));
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = B+12; dbg_wdata = 32'h2; dbg_fn3 = 3'b010;
    for (int s = 1; s <= 10; s++) begin
      logic d;
      d = (s == 5) || (s == 10);
      #1 chk($sformatf("starve_slot%0d", s), O(!d, d, 0,0,0,0, 32'h0, 32'h0, 1, d ? B+12 : B+8));
      @(negedge clk);
    end

    // Reset while a CPU load is pending
    drive(CI(0, B+4, 32'h0, 3'b010));
    #1 chk("rst_ld_gnt", O(1,0,0,0,0,0,32'h0,0,0,B+4));
    @(negedge clk);
    drive(NI());
    rst_n = 1'b0;
    #1 chk("rst_in_rd", O(0,0,0,0,0,0,32'h0,0,0,B));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release", O(0,0,0,0,0,0,32'h0,0,0,B));
    @(negedge clk);
    #1 chk("rst_no_rvalid", O(0,0,0,0,0,0,32'h0,0,0,B));
    @(negedge clk);
    drive(CI(0, B+4, 32'h0, 3'b010));
    #1 chk("post_rst_gnt", O(1,0,0,0,0,0,32'h0,0,0,B+4));
    @(negedge clk);
    drive(NI());
    #1 chk("post_rst_rvalid", O(0,0,1,0,0,0,32'hDEAD_BEEF,0,0,B+4));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
